// File: rtl/dnn_feeder_pkg.sv
// dnn_feeder_pkg: shared derivations, write-FSM states and label slicing for dnn_sample_feeder.
package dnn_feeder_pkg;
    typedef enum logic {FILL, FULL} wr_state_t;

    function automatic int calc_ch(input int n0, input int fo0, input int z0);
        return n0 * fo0 / z0;
    endfunction

    function automatic int calc_cpc(input int ch);
        return ch + 2;
    endfunction

    function automatic int calc_act_w(input int width_in, input int z0, input int fo0);
        return width_in * z0 / fo0;
    endfunction

    // bit b is set when the label selects ideal output idx*yo+b
    function automatic logic [31:0] onehot_slice(input int label, input int idx, input int yo);
        logic [31:0] s;
        s = '0;
        for (int b = 0; b < 32; b++)
            s[b] = (b < yo) && (label == idx * yo + b);
        return s;
    endfunction
endpackage

// File: rtl/dnn_sample_feeder_bank.sv
// feeder_bank: one sample buffer of CH activation chunks plus label and eta,
// one write port and a combinational chunk read port.
module feeder_bank
    import dnn_feeder_pkg::*;
#(
    parameter int CH    = 16,
    parameter int ACT_W = 512,
    parameter int LW    = 4,
    parameter int width = 10,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PW-1:0]    wr_ptr,
    input  logic [ACT_W-1:0] act,
    input  logic [LW-1:0]    label,
    input  logic [width-1:0] eta,
    input  logic [PW-1:0]    rd_ptr,
    output logic [ACT_W-1:0] rd_act,
    output logic [LW-1:0]    rd_label,
    output logic [width-1:0] rd_eta
);
    logic [ACT_W-1:0] mem [CH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr] <= act;
            if (wr_ptr == '0) begin
                rd_label <= label;
                rd_eta   <= eta;
            end
        end
    end

    assign rd_act = mem[rd_ptr];
endmodule

// File: rtl/dnn_sample_feeder.sv
// dnn_sample_feeder: double-buffered sample source replaying one chunk per clk per block cycle.
// Optional DNN_FEEDER_STATS_EN adds saturating samples_fed / bubbles counters.
module dnn_sample_feeder
    import dnn_feeder_pkg::*;
#(
    parameter int width    = 10,
    parameter int width_in = 8,
    parameter int n0       = 1024,
    parameter int nL       = 16,
    parameter int z0       = 512,
    parameter int fo0      = 8,
    parameter int yo       = 1,
    localparam int CH      = calc_ch(n0, fo0, z0),
    localparam int cpc     = calc_cpc(CH),
    localparam int ACT_W   = calc_act_w(width_in, z0, fo0)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cycle_clk,
    input  logic [$clog2(cpc)-1:0]  cycle_index,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [ACT_W-1:0]        s_act,
    input  logic [$clog2(nL)-1:0]   s_label,
    input  logic [width-1:0]        s_eta,
    output logic [ACT_W-1:0]        a_in,
    output logic [yo-1:0]           y_in,
    output logic [width-1:0]        eta_in,
    output logic                    sample_live
`ifdef DNN_FEEDER_STATS_EN
    ,
    output logic [31:0]             samples_fed,
    output logic [31:0]             bubbles
`endif
);
    localparam int PW = $clog2(CH);
    localparam int IW = $clog2(cpc);
    localparam int LW = $clog2(nL);

    wr_state_t        state;
    logic [PW-1:0]    wr_ptr;
    logic             rb;
    logic             hs;
    logic             idx_ok;
    logic [ACT_W-1:0] act0, act1;
    logic [LW-1:0]    lab0, lab1, rd_label;
    logic [width-1:0] eta0, eta1, rd_eta;

    assign s_ready = state == FILL;
    assign hs      = s_valid && s_ready;

    // hs and a swap never coincide: a swap needs FULL, a handshake needs FILL
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FILL;
            wr_ptr      <= '0;
            rb          <= 1'b0;
            sample_live <= 1'b0;
        end else begin
            if (cycle_clk) begin
                sample_live <= state == FULL;
                if (state == FULL) begin
                    rb     <= ~rb;
                    state  <= FILL;
                    wr_ptr <= '0;
                end
            end
            if (hs) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_ptr == PW'(CH - 1))
                    state <= FULL;
            end
        end
    end

    feeder_bank #(.CH(CH), .ACT_W(ACT_W), .LW(LW), .width(width), .PW(PW)) bank0 (
        .clk(clk), .we(hs && rb), .wr_ptr(wr_ptr), .act(s_act), .label(s_label), .eta(s_eta),
        .rd_ptr(cycle_index[PW-1:0]), .rd_act(act0), .rd_label(lab0), .rd_eta(eta0)
    );

    feeder_bank #(.CH(CH), .ACT_W(ACT_W), .LW(LW), .width(width), .PW(PW)) bank1 (
        .clk(clk), .we(hs && !rb), .wr_ptr(wr_ptr), .act(s_act), .label(s_label), .eta(s_eta),
        .rd_ptr(cycle_index[PW-1:0]), .rd_act(act1), .rd_label(lab1), .rd_eta(eta1)
    );

    assign rd_label = rb ? lab1 : lab0;
    assign rd_eta   = rb ? eta1 : eta0;
    assign idx_ok   = sample_live && cycle_index < IW'(CH);
    assign a_in     = idx_ok ? (rb ? act1 : act0) : '0;
    assign y_in     = idx_ok ? yo'(onehot_slice(int'(rd_label), int'(cycle_index), yo)) : '0;
    assign eta_in   = sample_live ? rd_eta : '0;

`ifdef DNN_FEEDER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samples_fed <= '0;
            bubbles     <= '0;
        end else if (cycle_clk) begin
            if (state == FULL && samples_fed != '1)
                samples_fed <= samples_fed + 1;
            if (state != FULL && bubbles != '1)
                bubbles <= bubbles + 1;
        end
    end
`endif
endmodule

// File: tb/tb_dnn_sample_feeder.sv
// tb_dnn_sample_feeder: scoreboard bench; each completed sample is queued with the
// block cycle it must appear in, every other block cycle must be a bubble.
module tb_dnn_sample_feeder;
    localparam int CH  = 16;
    localparam int CPC = 18;

    typedef struct {
        int         due;
        logic [7:0] base;
        logic [3:0] label;
        logic [9:0] eta;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         cyc;
    logic [4:0]   idx;
    logic         s_valid;
    logic         s_ready;
    logic [511:0] s_act;
    logic [3:0]   s_label;
    logic [9:0]   s_eta;
    logic [511:0] a_in;
    logic [0:0]   y_in;
    logic [9:0]   eta_in;
    logic         sample_live;
`ifdef DNN_FEEDER_STATS_EN
    logic [31:0]  samples_fed;
    logic [31:0]  bubbles;
`endif

    int   checks = 0;
    int   errors = 0;
    int   blk = 0;
    int   last_hidx;
    bit   started = 0;
    bit   cur_live = 0;
    exp_t cur;
    exp_t q[$];

    always #5 clk = ~clk;

    dnn_sample_feeder dut (
        .clk(clk), .reset(reset), .cycle_clk(cyc), .cycle_index(idx),
        .s_valid(s_valid), .s_ready(s_ready), .s_act(s_act), .s_label(s_label), .s_eta(s_eta),
        .a_in(a_in), .y_in(y_in), .eta_in(eta_in), .sample_live(sample_live)
`ifdef DNN_FEEDER_STATS_EN
        , .samples_fed(samples_fed), .bubbles(bubbles)
`endif
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h exp %h", tag, $time, got, exp);
        end
    endtask

    // cycle counter lives here so it never races the stimulus
    task automatic step();
        @(posedge clk);
        #1;
        if (reset)
            idx = '0;
        else begin
            idx = idx == 5'(CPC - 1) ? 5'd0 : idx + 5'd1;
            if (idx == 0) blk++;
        end
        cyc = idx == 5'(CPC - 1);
    endtask

    task automatic send_chunk(input logic [7:0] v, input logic [3:0] lab, input logic [9:0] e,
                              output int hidx, output int hblk);
        bit done = 0;
        s_valid = 1'b1;
        s_act   = {64{v}};
        s_label = lab;
        s_eta   = e;
        hidx    = 0;
        hblk    = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            done = s_ready;
            hidx = int'(idx);
            hblk = blk;
            step();
        end
        chk("hs_timeout", done, 1);
        s_valid = 1'b0;
    endtask

    // label/eta are only valid on chunk 0; other chunks carry decoys
    task automatic send_chunks(input logic [7:0] base, input logic [3:0] lab, input logic [9:0] e,
                               input int k0, input int k1, output int due);
        int hidx, hblk;
        due = -1;
        for (int k = k0; k <= k1; k++)
            send_chunk(8'(base + 8'(k)), k == 0 ? lab : ~lab, k == 0 ? e : ~e, hidx, hblk);
        last_hidx = hidx;
        if (k1 == CH - 1) begin
            due = hidx == CPC - 1 ? hblk + 2 : hblk + 1;
            q.push_back('{due, base, lab, e});
            chk("full_ready", s_ready, 0);
        end
    endtask

    always @(negedge clk) begin
        logic [511:0] ea;
        if (!reset && started) begin
            if (idx == 0) begin
                if (q.size() > 0 && q[0].due < blk) begin
                    chk("late", blk, q[0].due);
                    void'(q.pop_front());
                end
                cur_live = q.size() > 0 && q[0].due == blk;
                if (cur_live) cur = q.pop_front();
            end
            ea = (cur_live && idx < CH) ? {64{8'(cur.base + 8'(idx))}} : '0;
            chk("live", sample_live, cur_live);
            chk("a_in", a_in, ea);
            chk("y_in", y_in, cur_live && idx < CH && idx == 5'(cur.label));
            chk("eta_in", eta_in, cur_live ? cur.eta : 10'd0);
        end
    end

    initial begin
        int da, db, dc, dd, dummy;
        reset = 1'b1; s_valid = 1'b0; s_act = '0; s_label = '0; s_eta = '0;
        idx = '0; cyc = 1'b0;
        repeat (2) step();
        chk("rst_ready", s_ready, 1);
        chk("rst_live", sample_live, 0);
        chk("rst_a", a_in, 0);
        chk("rst_y", y_in, 0);
        chk("rst_eta", eta_in, 0);
        reset = 1'b0; blk++; started = 1;

        repeat (3 * CPC) step();
`ifdef DNN_FEEDER_STATS_EN
        chk("bubbles", bubbles, 3);
        chk("fed0", samples_fed, 0);
`endif
        send_chunks(8'h00, 4'd5, 10'h040, 0, CH - 1, dummy);

        send_chunks(8'h20, 4'd3, 10'h011, 0, CH - 1, da);
        send_chunks(8'h40, 4'd15, 10'h3ff, 0, CH - 1, db);
        send_chunks(8'h60, 4'd0, 10'h001, 0, CH - 1, dc);
        chk("b2b_ab", db, da + 1);
        chk("b2b_bc", dc, db + 1);

        for (int n = 0; n < 200 && !(idx == 2 && s_ready); n++) step();
        chk("align_to", idx == 2 && s_ready, 1);
        send_chunks(8'h80, 4'd9, 10'h155, 0, CH - 1, dummy);
        chk("coinc_phase", last_hidx, CPC - 1);

        for (int n = 0; n < 200 && !s_ready; n++) step();
        send_chunks(8'hA0, 4'd12, 10'h0AA, 0, 6, dummy);
        repeat (CPC + 2) step();
        chk("stall_ready", s_ready, 1);
        send_chunks(8'hA0, 4'd12, 10'h0AA, 7, CH - 1, dummy);

        send_chunks(8'hC0, 4'd7, 10'h2F0, 0, CH - 1, dd);
        send_chunks(8'hD0, 4'd2, 10'h0F0, 0, 3, dummy);
        for (int n = 0; n < 200 && !(blk == dd && idx == 9); n++) step();
        chk("rst_align", blk == dd && idx == 9, 1);
        chk("pre_rst_live", sample_live, 1);
        reset = 1'b1;
        #1;
        chk("arst_live", sample_live, 0);
        chk("arst_a", a_in, 0);
        chk("arst_y", y_in, 0);
        chk("arst_eta", eta_in, 0);
        step();
        chk("arst_ready", s_ready, 1);
        q.delete();
        reset = 1'b0; blk++;

        send_chunks(8'hE0, 4'd14, 10'h123, 0, CH - 1, dummy);
        for (int n = 0; n < 200 && q.size() != 0; n++) step();
        repeat (CPC) step();
        chk("q_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
